// File: rtl/plot_arb_pkg.sv
// rtl/plot_arb_pkg.sv - shared types and width helpers for the pixel plot arbiter
package plot_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        CLEAR = 2'd2
    } state_t;

    localparam int COLOUR_W = 3;

    function automatic int x_width(input int screen_width);
        return $clog2(screen_width) + 1;
    endfunction

    function automatic int y_width(input int screen_height);
        return $clog2(screen_height) + 1;
    endfunction

endpackage

// File: rtl/clear_sweeper.sv
// rtl/clear_sweeper.sv - raster x/y counter for the clear sweep
// start steps past the origin (the caller emits (0,0) itself); advance steps from the current pixel.
module clear_sweeper
    import plot_arb_pkg::*;
#(
    parameter int SCREEN_WIDTH  = 320,
    parameter int SCREEN_HEIGHT = 240,
    localparam int XW = x_width(SCREEN_WIDTH),
    localparam int YW = y_width(SCREEN_HEIGHT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          advance,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last
);

    localparam logic [XW-1:0] X_MAX = XW'(SCREEN_WIDTH - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(SCREEN_HEIGHT - 1);

    logic [XW-1:0] cur_x;
    logic [XW-1:0] nxt_x;
    logic [YW-1:0] cur_y;
    logic [YW-1:0] nxt_y;

    always_comb begin
        cur_x = start ? '0 : x;
        cur_y = start ? '0 : y;
        nxt_x = cur_x + XW'(1);
        nxt_y = cur_y;
        if (cur_x == X_MAX) begin
            nxt_x = '0;
            nxt_y = (cur_y == Y_MAX) ? '0 : cur_y + YW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
        end else if (start || advance) begin
            x <= nxt_x;
            y <= nxt_y;
        end
    end

    assign last = (x == X_MAX) && (y == Y_MAX);

endmodule

// File: rtl/plot_arbiter.sv
// rtl/plot_arbiter.sv - round-robin arbiter of two pixel writers plus a clear-screen sweep
module plot_arbiter
    import plot_arb_pkg::*;
#(
    parameter int SCREEN_WIDTH  = 320,
    parameter int SCREEN_HEIGHT = 240,
    localparam int XW = x_width(SCREEN_WIDTH),
    localparam int YW = y_width(SCREEN_HEIGHT)
) (
    input  logic                iClk,
    input  logic                iResetn,
    input  logic                iClear,
    input  logic [COLOUR_W-1:0] iClearColour,
    input  logic                iReqA,
    input  logic [XW-1:0]       iXA,
    input  logic [YW-1:0]       iYA,
    input  logic [COLOUR_W-1:0] iColourA,
    output logic                oAckA,
    input  logic                iReqB,
    input  logic [XW-1:0]       iXB,
    input  logic [YW-1:0]       iYB,
    input  logic [COLOUR_W-1:0] iColourB,
    output logic                oAckB,
    output logic [XW-1:0]       oX,
    output logic [YW-1:0]       oY,
    output logic [COLOUR_W-1:0] oColour,
    output logic                oPlot,
    output logic                oBusy,
    output logic                oDropped
);

    localparam logic [XW-1:0] X_LIM = XW'(SCREEN_WIDTH);
    localparam logic [YW-1:0] Y_LIM = YW'(SCREEN_HEIGHT);
    localparam bit ONE_PIXEL = (SCREEN_WIDTH == 1) && (SCREEN_HEIGHT == 1);

    state_t state;
    state_t next_state;

    logic                last_a;
    logic                elig_a;
    logic                elig_b;
    logic                grant_a;
    logic                grant_b;
    logic                sweep_start;
    logic                sweep_advance;
    logic [XW-1:0]       sw_x;
    logic [YW-1:0]       sw_y;
    logic                sw_last;
    logic [XW-1:0]       sel_x;
    logic [YW-1:0]       sel_y;
    logic [COLOUR_W-1:0] sel_colour;
    logic                sel_in_range;

    clear_sweeper #(
        .SCREEN_WIDTH (SCREEN_WIDTH),
        .SCREEN_HEIGHT(SCREEN_HEIGHT)
    ) u_sweeper (
        .clk    (iClk),
        .rst_n  (iResetn),
        .start  (sweep_start),
        .advance(sweep_advance),
        .x      (sw_x),
        .y      (sw_y),
        .last   (sw_last)
    );

    // A requester still showing its ack is mid-handshake and must not be granted again.
    assign elig_a = iReqA && !oAckA;
    assign elig_b = iReqB && !oAckB;

    assign sel_x        = grant_b ? iXB : iXA;
    assign sel_y        = grant_b ? iYB : iYA;
    assign sel_colour   = grant_b ? iColourB : iColourA;
    assign sel_in_range = (sel_x < X_LIM) && (sel_y < Y_LIM);

    always_ff @(posedge iClk or negedge iResetn) begin
        if (!iResetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state    = state;
        grant_a       = 1'b0;
        grant_b       = 1'b0;
        sweep_start   = 1'b0;
        sweep_advance = 1'b0;
        case (state)
            IDLE, SERVE: begin
                if (iClear) begin
                    sweep_start = 1'b1;
                    next_state  = ONE_PIXEL ? IDLE : CLEAR;
                end else if (elig_a && (!elig_b || !last_a)) begin
                    grant_a    = 1'b1;
                    next_state = SERVE;
                end else if (elig_b) begin
                    grant_b    = 1'b1;
                    next_state = SERVE;
                end else begin
                    next_state = IDLE;
                end
            end
            CLEAR: begin
                sweep_advance = 1'b1;
                if (sw_last) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // The origin pixel is emitted on the start edge; later sweep pixels come from the counter.
    always_ff @(posedge iClk or negedge iResetn) begin
        if (!iResetn) begin
            last_a   <= 1'b0;
            oX       <= '0;
            oY       <= '0;
            oColour  <= '0;
            oPlot    <= 1'b0;
            oAckA    <= 1'b0;
            oAckB    <= 1'b0;
            oBusy    <= 1'b0;
            oDropped <= 1'b0;
        end else begin
            oAckA    <= grant_a;
            oAckB    <= grant_b;
            oPlot    <= 1'b0;
            oBusy    <= 1'b0;
            oDropped <= 1'b0;
            if (sweep_start || sweep_advance) begin
                oPlot <= 1'b1;
                oBusy <= 1'b1;
                oX    <= sweep_start ? '0 : sw_x;
                oY    <= sweep_start ? '0 : sw_y;
                if (sweep_start) begin
                    oColour <= iClearColour;
                end
            end else if (grant_a || grant_b) begin
                last_a <= grant_a;
                if (sel_in_range) begin
                    oPlot   <= 1'b1;
                    oX      <= sel_x;
                    oY      <= sel_y;
                    oColour <= sel_colour;
                end else begin
                    oDropped <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_plot_arbiter.sv
// tb/tb_plot_arbiter.sv - directed vector bench for plot_arbiter
module tb_plot_arbiter;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    // full-size instance
    logic       clr = 0, ra = 0, rb = 0;
    logic [2:0] cc = 0, ca = 0, cb = 0;
    logic [9:0] xa = 0, xb = 0;
    logic [8:0] ya = 0, yb = 0;
    logic       acka, ackb, plot, busy, drop;
    logic [9:0] ox;
    logic [8:0] oy;
    logic [2:0] oc;

    plot_arbiter dut (
        .iClk(clk), .iResetn(rstn), .iClear(clr), .iClearColour(cc),
        .iReqA(ra), .iXA(xa), .iYA(ya), .iColourA(ca), .oAckA(acka),
        .iReqB(rb), .iXB(xb), .iYB(yb), .iColourB(cb), .oAckB(ackb),
        .oX(ox), .oY(oy), .oColour(oc), .oPlot(plot), .oBusy(busy), .oDropped(drop)
    );

    // 4x2 instance for the full clear sweep
    logic       s_clr = 0, s_ra = 0, s_rb = 0;
    logic [2:0] s_cc = 0, s_ca = 0, s_cb = 0;
    logic [2:0] s_xa = 0, s_xb = 0;
    logic [1:0] s_ya = 0, s_yb = 0;
    logic       s_acka, s_ackb, s_plot, s_busy, s_drop;
    logic [2:0] s_ox;
    logic [1:0] s_oy;
    logic [2:0] s_oc;

    plot_arbiter #(.SCREEN_WIDTH(4), .SCREEN_HEIGHT(2)) dut_s (
        .iClk(clk), .iResetn(rstn), .iClear(s_clr), .iClearColour(s_cc),
        .iReqA(s_ra), .iXA(s_xa), .iYA(s_ya), .iColourA(s_ca), .oAckA(s_acka),
        .iReqB(s_rb), .iXB(s_xb), .iYB(s_yb), .iColourB(s_cb), .oAckB(s_ackb),
        .oX(s_ox), .oY(s_oy), .oColour(s_oc), .oPlot(s_plot), .oBusy(s_busy), .oDropped(s_drop)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic       ra;
        logic [9:0] xa;
        logic [8:0] ya;
        logic [2:0] ca;
        logic       rb;
        logic [9:0] xb;
        logic [8:0] yb;
        logic [2:0] cb;
        logic [9:0] ex;
        logic [8:0] ey;
        logic [2:0] ec;
        logic [4:0] es;   // {plot, ack_a, ack_b, busy, dropped}
    } vec_t;

    vec_t vecs[16];

    function automatic logic [63:0] pk(input logic [9:0] x, input logic [8:0] y,
                                       input logic [2:0] c, input logic [4:0] s);
        return {37'd0, x, y, c, s};
    endfunction

    function automatic vec_t mk(input logic r_a, input int x_a, input int y_a, input int c_a,
                                input logic r_b, input int x_b, input int y_b, input int c_b,
                                input int e_x, input int e_y, input int e_c, input logic [4:0] e_s);
        vec_t v;
        v.ra = r_a; v.xa = 10'(x_a); v.ya = 9'(y_a); v.ca = 3'(c_a);
        v.rb = r_b; v.xb = 10'(x_b); v.yb = 9'(y_b); v.cb = 3'(c_b);
        v.ex = 10'(e_x); v.ey = 9'(e_y); v.ec = 3'(e_c); v.es = e_s;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] big_out();
        return pk(ox, oy, oc, {plot, acka, ackb, busy, drop});
    endfunction

    function automatic logic [63:0] small_out();
        return pk(10'(s_ox), 9'(s_oy), s_oc, {s_plot, s_acka, s_ackb, s_busy, s_drop});
    endfunction

    initial begin
        //              ra xa  ya  ca  rb xb   yb cb   ex  ey  ec  {plot,aa,ab,busy,drop}
        vecs[0]  = mk(0,  0,  0, 0, 0,   0, 0, 0,    0,  0, 0, 5'b00000);
        vecs[1]  = mk(1, 10, 20, 5, 0,   0, 0, 0,   10, 20, 5, 5'b11000);
        vecs[2]  = mk(1, 10, 20, 5, 0,   0, 0, 0,   10, 20, 5, 5'b00000);
        vecs[3]  = mk(0,  0,  0, 0, 0,   0, 0, 0,   10, 20, 5, 5'b00000);
        vecs[4]  = mk(1,  1,  2, 1, 1,   3, 4, 2,    3,  4, 2, 5'b10100);
        vecs[5]  = mk(1,  1,  2, 1, 1,   3, 4, 2,    1,  2, 1, 5'b11000);
        vecs[6]  = mk(1,  1,  2, 1, 1,   3, 4, 2,    3,  4, 2, 5'b10100);
        vecs[7]  = mk(1,  1,  2, 1, 1,   3, 4, 2,    1,  2, 1, 5'b11000);
        vecs[8]  = mk(0,  0,  0, 0, 1,   3, 4, 2,    3,  4, 2, 5'b10100);
        vecs[9]  = mk(0,  0,  0, 0, 1, 320, 5, 7,    3,  4, 2, 5'b00000);
        vecs[10] = mk(0,  0,  0, 0, 1, 320, 5, 7,    3,  4, 2, 5'b00101);
        vecs[11] = mk(1,  5,240, 6, 0,   0, 0, 0,    3,  4, 2, 5'b01001);
        vecs[12] = mk(0,  0,  0, 0, 0,   0, 0, 0,    3,  4, 2, 5'b00000);
        vecs[13] = mk(1,319,239, 4, 0,   0, 0, 0,  319,239, 4, 5'b11000);
        vecs[14] = mk(0,  0,  0, 0, 0,   0, 0, 0,  319,239, 4, 5'b00000);
        vecs[15] = mk(1,  7,  7, 7, 1,   0, 0, 3,    0,  0, 3, 5'b10100);

        // reset state, asserted with no clock edge relied upon
        #2;
        check("reset_big", big_out(), 64'd0);
        check("reset_small", small_out(), 64'd0);
        @(posedge clk); #1;
        rstn = 1'b1;

        // table-driven arbitration vectors on the full-size instance
        for (int i = 0; i < 16; i++) begin
            ra = vecs[i].ra; xa = vecs[i].xa; ya = vecs[i].ya; ca = vecs[i].ca;
            rb = vecs[i].rb; xb = vecs[i].xb; yb = vecs[i].yb; cb = vecs[i].cb;
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), big_out(),
                  pk(vecs[i].ex, vecs[i].ey, vecs[i].ec, vecs[i].es));
        end
        ra = 0; rb = 0;

        // clear and request together on the 4x2 instance; second clear mid-sweep is ignored
        s_clr = 1; s_cc = 3'd3;
        s_ra = 1; s_xa = 3'd1; s_ya = 2'd1; s_ca = 3'd2;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            s_clr = (i == 2);
            check($sformatf("sweep%0d", i), small_out(),
                  pk(10'(i % 4), 9'(i / 4), 3'd3, 5'b10010));
        end
        @(posedge clk); #1;
        check("after_sweep_ack_a", small_out(), pk(10'd1, 9'd1, 3'd2, 5'b11000));
        s_ra = 0;
        @(posedge clk); #1;
        check("after_sweep_idle", small_out(), pk(10'd1, 9'd1, 3'd2, 5'b00000));

        // out-of-range x on the small instance
        s_rb = 1; s_xb = 3'd4; s_yb = 2'd0; s_cb = 3'd7;
        @(posedge clk); #1;
        check("small_drop_b", small_out(), pk(10'd1, 9'd1, 3'd2, 5'b00101));
        s_rb = 0;

        // reset mid-clear at pixel (100,50) on the full-size instance
        clr = 1; cc = 3'd6;
        begin
            bit found;
            found = 0;
            for (int n = 0; n < 20000 && !found; n++) begin
                @(posedge clk); #1;
                clr = 0;
                if (plot && ox == 10'd100 && oy == 9'd50) found = 1;
            end
            check("reach_pixel_100_50", 64'(found), 64'd1);
        end
        rstn = 1'b0;
        #1;
        check("midclear_reset", big_out(), 64'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check($sformatf("post_reset_quiet%0d", i), big_out(), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/plot_arbiter.md
PLOT_ARBITER -- requirements
Module: plot_arbiter

Interface
REQ-001 Parameter SCREEN_WIDTH, default 320, shall set the horizontal pixel count.
REQ-002 Parameter SCREEN_HEIGHT, default 240, shall set the vertical pixel count.
REQ-003 Ports shall be:
- iClk  in  1  system clock, all logic on rising edge.
- iResetn  in  1  asynchronous, active-low reset.
- iClear  in  1  single-cycle clear-screen request.
- iClearColour  in  3  fill colour for the clear sweep.
- iReqA  in  1  brush requester write request.
- iXA  in  XW  brush x, where XW = $clog2(SCREEN_WIDTH)+1.
- iYA  in  YW  brush y, where YW = $clog2(SCREEN_HEIGHT)+1.
- iColourA  in  3  brush colour.
- oAckA  out  1  brush request accepted.
- iReqB, iXB, iYB, iColourB, oAckB: cursor requester, identical to A.
- oX  out  XW  pixel x to vga_adapter.
- oY  out  YW  pixel y to vga_adapter.
- oColour  out  3  pixel colour to vga_adapter.
- oPlot  out  1  write strobe to vga_adapter.
- oBusy  out  1  clear sweep in progress.
- oDropped  out  1  accepted request was out of range and not plotted.

Function
REQ-004 All outputs shall be registered; a grant decided at edge k shall appear on the outputs in the cycle after edge k (latency 1).
REQ-005 Requester handshake:
- The requester holds iReqX and its data stable until it sees oAckX=1.
- oAckX shall be a one-cycle pulse.
- The arbiter shall not grant requester X at an edge where oAckX is already 1, so each requester gets at most one grant every two cycles.
REQ-006 The FSM shall have states IDLE, SERVE and CLEAR; the reset state is IDLE.
REQ-007 IDLE or SERVE with iClear=1 shall go to CLEAR.
- iClear takes priority over any pending iReqA/iReqB in the same cycle.
- No ack is issued on that edge.
REQ-008 IDLE or SERVE with no clear and at least one eligible request shall go to SERVE and grant exactly one requester.
REQ-009 IDLE or SERVE with no clear and no eligible request shall go to IDLE; oPlot, oAckA, oAckB and oDropped shall all be 0.
REQ-010 Arbitration shall be round-robin:
- A lone eligible requester is granted.
- When both are eligible, the one not granted most recently is granted.
- The last-grant pointer resets to favour A.
REQ-011 A granted request with x >= SCREEN_WIDTH or y >= SCREEN_HEIGHT shall pulse oAckX=1 and oDropped=1 with oPlot=0.
REQ-012 In CLEAR, one pixel per cycle:
- oX/oY sweep in raster order: x 0..W-1 inner, y 0..H-1 outer.
- oColour = iClearColour as sampled at the clear start.
- oPlot=1 and oBusy=1 for exactly W*H cycles.
REQ-013 After the pixel (W-1, H-1) the FSM shall return to IDLE on the next edge.
- oBusy falls in the same cycle oPlot falls.
- Counters wrap to 0.
REQ-014 iClear asserted while in CLEAR shall be ignored; the sweep shall not restart.
REQ-015 No acks shall be issued in CLEAR; requests pending during a clear stay pending and are arbitrated normally from the first IDLE/SERVE edge.
REQ-016 oX, oY and oColour shall hold their last values when oPlot=0.

Reset
REQ-017 With iResetn=0, regardless of clock:
- state = IDLE, sweep counters = 0, pointer favours A.
- oX=0, oY=0, oColour=0.
- oPlot=0, oAckA=0, oAckB=0, oBusy=0, oDropped=0.
REQ-018 Reset asserted mid-clear shall abort the sweep; after release the block shall be in IDLE with no clear pending.

Structure
REQ-019 A shared package plot_arb_pkg shall hold:
- the state enum (IDLE, SERVE, CLEAR);
- the width functions for XW and YW;
- the colour width constant 3.
REQ-020 The raster x/y counter with its done flag shall be a sub-module clear_sweeper, parameterised by SCREEN_WIDTH and SCREEN_HEIGHT, with start, advance, x, y and last ports.

Verification
REQ-021 iReqA=1 at (10,20,colour 5), B idle -> one cycle later oPlot=1, oX=10, oY=20, oColour=5, oAckA=1; no second plot while the request is held through the ack cycle.
REQ-022 A and B request continuously -> grants alternate A, B, A, B, one per cycle, each requester acked every second cycle.
REQ-023 iClear pulse with iClearColour=3, W=4, H=2 override -> oPlot high exactly 8 cycles, coordinates (0,0),(1,0)...(3,1), oBusy high for the same 8 cycles; a request held throughout is acked only after oBusy falls.
REQ-024 iReqB at (320,5) -> oAckB=1, oDropped=1, oPlot=0, outputs unchanged.
REQ-025 iResetn low during a clear at pixel (100,50), then released -> all outputs 0, oBusy=0, no further plots without a new iClear.
REQ-026 iClear and iReqA in the same cycle -> CLEAR entered, oAckA=0 until the sweep ends, then A is served.
